cpu: RTL and testbench

- Minimal 4-bit switch-driven ALU "CPU" for FPGA board use.
- Two 4-bit operands come from eight slide switches; a 2-bit opcode selects ADD, SUB, AND or OR.
- The result is captured into a 4-bit output register on an enabled clock edge and drives board LEDs.
- Top-level leaf block; no submodules are required.

---
 rtl/cpu.sv | 54 +++++
 tb/tb_cpu.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: switch-driven 4-bit ALU (ADD/SUB/AND/OR) with a registered LED result; define FLAGS_EN to add carry/zero flag outputs.
module cpu #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             SW0,
  input  logic             SW1,
  input  logic             SW2,
  input  logic             SW3,
  input  logic             SW4,
  input  logic             SW5,
  input  logic             SW6,
  input  logic             SW7,
  input  logic             enable,
  input  logic [1:0]       operation,
`ifdef FLAGS_EN
  output logic             carry,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] rezult
);
  logic [WIDTH-1:0] a, b, f;
  assign a = {SW3, SW2, SW1, SW0};
  assign b = {SW7, SW6, SW5, SW4};
  always_comb begin
    f = operation == 2'b00 ? a + b :
        operation == 2'b01 ? a - b :
        operation == 2'b10 ? a & b : a | b;
  end
`ifdef FLAGS_EN
  // an add wrapped exactly when its truncated sum is below an operand
  logic c;
  always_comb begin
    c = operation == 2'b00 ? f < a :
        operation == 2'b01 ? a < b : 1'b0;
  end
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rezult <= '0;
`ifdef FLAGS_EN
      carry  <= 1'b0;
      zero   <= 1'b0;
`endif
    end else if (enable) begin
      rezult <= f;
`ifdef FLAGS_EN
      carry  <= c;
      zero   <= f == '0;
`endif
    end
  end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: scoreboard bench for cpu; expectations queued at drive time and checked one edge later.
module tb_cpu;
  logic clock, reset_n, enable;
  logic SW0, SW1, SW2, SW3, SW4, SW5, SW6, SW7;
  logic [1:0] operation;
  logic [3:0] rezult;
`ifdef FLAGS_EN
  logic carry, zero;
`endif
  int errors = 0;
  int checks = 0;
  logic [5:0] q[$];
  logic [3:0] held = 0;
  logic hc = 0, hz = 0;

  cpu dut (
    .clock(clock), .reset_n(reset_n),
    .SW0(SW0), .SW1(SW1), .SW2(SW2), .SW3(SW3),
    .SW4(SW4), .SW5(SW5), .SW6(SW6), .SW7(SW7),
    .enable(enable), .operation(operation),
`ifdef FLAGS_EN
    .carry(carry), .zero(zero),
`endif
    .rezult(rezult)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  function automatic int model(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic check_now(input string name, input logic [5:0] e);
    checks++;
    if (rezult !== e[3:0]) begin
      errors++;
      $display("FAIL %s: rezult=%0d expected=%0d", name, rezult, e[3:0]);
    end
`ifdef FLAGS_EN
    checks++;
    if ({carry, zero} !== e[5:4]) begin
      errors++;
      $display("FAIL %s flags: carry,zero=%b%b expected=%b%b", name, carry, zero, e[5], e[4]);
    end
`endif
  endtask

  task automatic cycle(input string name, input int a, input int b, input int op, input logic en);
    @(negedge clock);
    {SW3, SW2, SW1, SW0} = 4'(a);
    {SW7, SW6, SW5, SW4} = 4'(b);
    operation = 2'(op);
    enable = en;
    if (!reset_n) begin
      held = 0; hc = 0; hz = 0;
    end else if (en) begin
      held = 4'(model(a, b, op));
      hc = op == 0 ? (a + b) > 15 : op == 1 ? a < b : 1'b0;
      hz = held == 0;
    end
    q.push_back({hc, hz, held});
    @(posedge clock);
    #1;
    check_now(name, q.pop_front());
  endtask

  task automatic test_reset;
    #1;
    check_now("reset_immediate", 6'd0);
    for (int i = 0; i < 3; i++) cycle("reset_held", 9, 3, 0, 1'b1);
    @(negedge clock);
    reset_n = 1;
    cycle("reset_release_sub", 15, 6, 1, 1'b1);
  endtask

  task automatic test_and;
    cycle("and_15_6", 15, 6, 2, 1'b1);
    cycle("and_10_12", 10, 12, 2, 1'b1);
  endtask

  task automatic test_add;
    cycle("add_9_6", 9, 6, 0, 1'b1);
    cycle("add_15_1_wrap", 15, 1, 0, 1'b1);
    cycle("add_7_8", 7, 8, 0, 1'b1);
  endtask

  task automatic test_sub;
    cycle("sub_0_1_wrap", 0, 1, 1, 1'b1);
    cycle("sub_6_6_zero", 6, 6, 1, 1'b1);
    cycle("sub_12_5", 12, 5, 1, 1'b1);
  endtask

  task automatic test_or;
    cycle("or_5_10", 5, 10, 3, 1'b1);
    cycle("or_0_0", 0, 0, 3, 1'b1);
  endtask

  task automatic test_hold;
    cycle("hold_capture", 15, 6, 1, 1'b1);
    for (int i = 0; i < 5; i++) cycle("hold", i * 3, 15 - i, i % 4, 1'b0);
  endtask

  task automatic test_async_reset;
    cycle("async_pre", 3, 4, 0, 1'b1);
    @(posedge clock);
    #3;
    reset_n = 0;
    #1;
    held = 0; hc = 0; hz = 0;
    check_now("async_reset_immediate", 6'd0);
    @(negedge clock);
    reset_n = 1;
    cycle("async_or_5_10", 5, 10, 3, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      cycle("random", int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(3)), 1'($urandom_range(1)));
  endtask

  initial begin
    reset_n = 0; enable = 1; operation = 0;
    {SW7, SW6, SW5, SW4, SW3, SW2, SW1, SW0} = 8'h00;
    test_reset;
    test_and;
    test_add;
    test_sub;
    test_or;
    test_hold;
    test_async_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
